// File: rtl/tlc_pkg.sv
// Shared types and constants for the multi-way sensor traffic light controller.
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } tlc_state_t;

  typedef struct packed {
    logic green;
    logic yellow;
    logic red;
  } lamp_t;

  localparam lamp_t LAMP_RED    = 3'b001;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_GREEN  = 3'b100;

  // Way-index width, never narrower than one bit.
  function automatic int unsigned way_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_way_picker.sv
// Round-robin way selector: first requesting way after cur_way, cur_way itself last.
module rr_way_picker
  import tlc_pkg::*;
#(
  parameter int unsigned N_WAYS = 4,
  parameter int unsigned WAY_W  = way_width(N_WAYS)
) (
  input  logic [N_WAYS-1:0] req,
  input  logic [WAY_W-1:0]  cur_way,
  output logic [WAY_W-1:0]  next_way,
  output logic              any_req
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    next_way = cur_way;
    any_req  = |req;
    for (int k = int'(N_WAYS); k >= 1; k--) begin
      logic [WAY_W-1:0] cand;
      cand = WAY_W'((int'(cur_way) + k) % int'(N_WAYS));
      if (req[cand]) next_way = cand;
    end
  end

endmodule

// File: rtl/tlc_multiway_sensor.sv
// N-way sensor-actuated traffic light controller with min/max green and
// yellow/all-red clearance; lamps are registered Moore outputs.
module tlc_multiway_sensor
  import tlc_pkg::*;
#(
  parameter  int unsigned N_WAYS    = 4,
  parameter  int unsigned CNT_W     = 8,
  parameter  int unsigned MIN_GREEN = 4,
  parameter  int unsigned MAX_GREEN = 16,
  parameter  int unsigned YELLOW_T  = 2,
  parameter  int unsigned ALLRED_T  = 1,
  localparam int unsigned WAY_W     = way_width(N_WAYS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_WAYS-1:0] sensor,
  output logic [N_WAYS-1:0] red,
  output logic [N_WAYS-1:0] yellow,
  output logic [N_WAYS-1:0] green,
  output logic [WAY_W-1:0]  active_way,
  output logic              active_valid
);

  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] TMR_MAX     = {CNT_W{1'b1}};

  tlc_state_t        state_q, state_d;
  logic [WAY_W-1:0]  cur_way_q, cur_way_d;
  logic [CNT_W-1:0]  tmr_q, tmr_d;

  logic [N_WAYS-1:0] red_q, red_d;
  logic [N_WAYS-1:0] yellow_q, yellow_d;
  logic [N_WAYS-1:0] green_q, green_d;
  logic [WAY_W-1:0]  active_way_q, active_way_d;
  logic              active_valid_q, active_valid_d;

  logic [WAY_W-1:0]  pick_way_c;
  logic              any_req_c;
  logic [N_WAYS-1:0] cur_mask_c;
  logic              own_c;
  logic              others_c;

  rr_way_picker #(
    .N_WAYS (N_WAYS),
    .WAY_W  (WAY_W)
  ) u_picker (
    .req      (sensor),
    .cur_way  (cur_way_q),
    .next_way (pick_way_c),
    .any_req  (any_req_c)
  );

  assign cur_mask_c = N_WAYS'(1) << cur_way_q;
  assign own_c      = |(sensor & cur_mask_c);
  assign others_c   = |(sensor & ~cur_mask_c);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ALL_RED;
      cur_way_q <= '0;
      tmr_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_way_q <= cur_way_d;
      tmr_q     <= tmr_d;
    end
  end

  // Phase sequencing; the timer restarts on every state change and saturates otherwise.
  always_comb begin
    state_d   = state_q;
    cur_way_d = cur_way_q;
    tmr_d     = tmr_q;
    unique case (state_q)
      ST_ALL_RED: begin
        if (tmr_q >= ALLRED_LAST && any_req_c) begin
          state_d   = ST_GREEN;
          cur_way_d = pick_way_c;
        end
      end
      ST_GREEN: begin
        if (tmr_q >= MIN_LAST && others_c && (!own_c || tmr_q >= MAX_LAST)) begin
          state_d = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (tmr_q == YELLOW_LAST) state_d = ST_ALL_RED;
      end
      default: state_d = ST_ALL_RED;
    endcase
    if (state_d != state_q)  tmr_d = '0;
    else if (tmr_q != TMR_MAX) tmr_d = tmr_q + CNT_W'(1);
  end

  // Lamp decode from the next state so the registered lamps track the state register.
  always_comb begin
    red_d          = '0;
    yellow_d       = '0;
    green_d        = '0;
    active_way_d   = cur_way_d;
    active_valid_d = (state_d != ST_ALL_RED);
    for (int i = 0; i < int'(N_WAYS); i++) begin
      lamp_t lamp;
      lamp = LAMP_RED;
      if (WAY_W'(i) == cur_way_d) begin
        unique case (state_d)
          ST_GREEN:  lamp = LAMP_GREEN;
          ST_YELLOW: lamp = LAMP_YELLOW;
          default:   lamp = LAMP_RED;
        endcase
      end
      red_d[i]    = lamp.red;
      yellow_d[i] = lamp.yellow;
      green_d[i]  = lamp.green;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_q          <= '1;
      yellow_q       <= '0;
      green_q        <= '0;
      active_way_q   <= '0;
      active_valid_q <= 1'b0;
    end else begin
      red_q          <= red_d;
      yellow_q       <= yellow_d;
      green_q        <= green_d;
      active_way_q   <= active_way_d;
      active_valid_q <= active_valid_d;
    end
  end

  assign red          = red_q;
  assign yellow       = yellow_q;
  assign green        = green_q;
  assign active_way   = active_way_q;
  assign active_valid = active_valid_q;

endmodule
